// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit feeder: sample width, stereo frame and pairer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2s_pkg;

    localparam int I2S_DW = 24;

    typedef struct packed {
        logic [I2S_DW-1:0] l;
        logic [I2S_DW-1:0] r;
    } frame_t;

    typedef enum logic {
        WAIT_L = 1'b0,
        HAVE_L = 1'b1
    } pair_state_t;

endpackage

// File: rtl/sync_frame_fifo.sv
// Single-clock frame FIFO with binary pointers carrying an extra wrap bit.
// Latency: registered read, dout valid the cycle after pop.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [AW:0] FULL_CNT = PW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    // Occupancy is the pointer difference; the wrap bit disambiguates full from empty.
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == FULL_CNT);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = dout_q;

    // Gate requests against occupancy and advance pointers / read register.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        dout_d   = do_pop ? mem[rd_ptr_q[AW-1:0]] : dout_q;
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Pointer and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/i2s_tx_feeder.sv
// Pairs interleaved L/R words into frames, buffers them and feeds the I2S transmitter.
// Latency: frame reaches the stage 2 cycles after push; l_sample same cycle as rd_en, r_sample/rd_valid one later.
// Backpressure: s_ready drops while the FIFO is full; an empty stage on rd_en yields silence and an underrun count.
module i2s_tx_feeder
    import i2s_pkg::*;
#(
    parameter int DW    = I2S_DW,
    parameter int DEPTH = 16,
    parameter int CW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [DW-1:0]          l_sample,
    output logic [DW-1:0]          r_sample,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic [CW-1:0]          underrun_cnt,
    output logic [CW-1:0]          sync_err_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic              ready_en_q, ready_en_d;
    pair_state_t       pstate_q, pstate_d;
    logic [DW-1:0]     l_hold_q, l_hold_d;
    logic [DW-1:0]     l_stage_q, l_stage_d;
    logic [DW-1:0]     r_stage_q, r_stage_d;
    logic [DW-1:0]     r_hold_q, r_hold_d;
    logic              stage_valid_q, stage_valid_d;
    logic              inflight_q, inflight_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CW-1:0]     und_q, und_d;
    logic [CW-1:0]     serr_q, serr_d;

    logic              accept;
    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [2*DW-1:0]   fifo_din, fifo_dout;
    logic              serr_inc, und_inc;

    // Input handshake is held off for one cycle after reset so nothing is taken mid-reset.
    assign s_ready      = ready_en_q && !fifo_full;
    assign accept       = s_valid && s_ready;
    assign fifo_din     = {l_hold_q, s_data};
    assign l_sample     = stage_valid_q ? l_stage_q : '0;
    assign r_sample     = r_hold_q;
    assign rd_valid     = rd_valid_q;
    assign underrun_cnt = und_q;
    assign sync_err_cnt = serr_q;

    sync_frame_fifo #(
        .WIDTH (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (level)
    );

    // Pairer: an L word must be followed by an R word; anything else is a framing error.
    always_comb begin
        pstate_d  = pstate_q;
        l_hold_d  = l_hold_q;
        fifo_push = 1'b0;
        serr_inc  = 1'b0;
        if (accept) begin
            case (pstate_q)
                WAIT_L: begin
                    if (s_last) begin
                        serr_inc = 1'b1;
                    end else begin
                        l_hold_d = s_data;
                        pstate_d = HAVE_L;
                    end
                end
                HAVE_L: begin
                    if (s_last) begin
                        fifo_push = 1'b1;
                        pstate_d  = WAIT_L;
                    end else begin
                        l_hold_d = s_data;
                        serr_inc = 1'b1;
                    end
                end
                default: pstate_d = WAIT_L;
            endcase
        end
    end

    // Stage refill and transmitter side: an in-flight read always lands, even across an rd_en.
    always_comb begin
        ready_en_d    = 1'b1;
        fifo_pop      = !stage_valid_q && !inflight_q && !fifo_empty;
        inflight_d    = fifo_pop;
        l_stage_d     = l_stage_q;
        r_stage_d     = r_stage_q;
        stage_valid_d = stage_valid_q;
        r_hold_d      = r_hold_q;
        rd_valid_d    = rd_valid_q;
        und_inc       = 1'b0;
        if (rd_en) begin
            r_hold_d      = stage_valid_q ? r_stage_q : '0;
            rd_valid_d    = stage_valid_q;
            stage_valid_d = 1'b0;
            und_inc       = !stage_valid_q;
        end
        if (inflight_q) begin
            l_stage_d     = fifo_dout[2*DW-1:DW];
            r_stage_d     = fifo_dout[DW-1:0];
            stage_valid_d = 1'b1;
        end
    end

    // Saturating status counters.
    always_comb begin
        und_d  = und_q;
        serr_d = serr_q;
        if (und_inc && (und_q != CNT_MAX)) begin
            und_d = und_q + CW'(1);
        end
        if (serr_inc && (serr_q != CNT_MAX)) begin
            serr_d = serr_q + CW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q    <= 1'b0;
            pstate_q      <= WAIT_L;
            l_hold_q      <= '0;
            l_stage_q     <= '0;
            r_stage_q     <= '0;
            r_hold_q      <= '0;
            stage_valid_q <= 1'b0;
            inflight_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            und_q         <= '0;
            serr_q        <= '0;
        end else begin
            ready_en_q    <= ready_en_d;
            pstate_q      <= pstate_d;
            l_hold_q      <= l_hold_d;
            l_stage_q     <= l_stage_d;
            r_stage_q     <= r_stage_d;
            r_hold_q      <= r_hold_d;
            stage_valid_q <= stage_valid_d;
            inflight_q    <= inflight_d;
            rd_valid_q    <= rd_valid_d;
            und_q         <= und_d;
            serr_q        <= serr_d;
        end
    end

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Bench for i2s_tx_feeder: directed stimulus, a frame-queue reference model checked every cycle,
// plus literal expectations for the key scenarios.
// Counters are narrowed so saturation is reachable in a short run.
module tb_i2s_tx_feeder;

    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] l_sample;
    logic [DW-1:0] r_sample;
    logic          rd_en;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic [CW-1:0] underrun_cnt;
    logic [CW-1:0] sync_err_cnt;

    int total = 0;
    int bad   = 0;

    i2s_tx_feeder #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .l_sample     (l_sample),
        .r_sample     (r_sample),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .level        (level),
        .underrun_cnt (underrun_cnt),
        .sync_err_cnt (sync_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Frames wait in a queue; the output slot takes the oldest one when empty,
    // and that frame becomes visible two cycles after it was taken.
    logic [2*DW-1:0] fq[$];
    logic [2*DW-1:0] slot;
    bit              has_slot;
    int              slot_rdy;
    bit              have_l;
    logic [DW-1:0]   held_l;
    int              m_und, m_serr;
    bit              m_rv;
    logic [DW-1:0]   m_rh;
    bit              m_up;
    int              cyc = 0;

    always @(negedge clk) begin
        bit sv, exp_rdy, pop_now;
        if (rst) begin
            fq.delete();
            has_slot = 0; have_l = 0; held_l = '0;
            m_und = 0; m_serr = 0; m_rv = 0; m_rh = '0; m_up = 0;
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_outputs", {l_sample, r_sample, 16'(level)}, 64'd0);
            chk("rst_flags", {rd_valid, underrun_cnt, sync_err_cnt}, 64'd0);
        end else begin
            sv      = has_slot && (cyc >= slot_rdy);
            exp_rdy = m_up && (fq.size() < DEPTH);
            chk("m_s_ready",  64'(s_ready),      64'(exp_rdy));
            chk("m_level",    64'(level),        64'(fq.size()));
            chk("m_l_sample", 64'(l_sample),     sv ? 64'(slot[2*DW-1:DW]) : 64'd0);
            chk("m_r_sample", 64'(r_sample),     64'(m_rh));
            chk("m_rd_valid", 64'(rd_valid),     64'(m_rv));
            chk("m_underrun", 64'(underrun_cnt), 64'(m_und));
            chk("m_sync_err", 64'(sync_err_cnt), 64'(m_serr));

            pop_now = !has_slot && (fq.size() > 0);
            if (rd_en) begin
                if (sv) begin
                    m_rv = 1; m_rh = slot[DW-1:0]; has_slot = 0;
                end else begin
                    m_rv = 0; m_rh = '0;
                    if (m_und < CMAX) m_und++;
                end
            end
            if (pop_now) begin
                slot = fq.pop_front(); has_slot = 1; slot_rdy = cyc + 2;
            end
            if (s_valid && exp_rdy) begin
                if (s_last) begin
                    if (have_l) begin
                        fq.push_back({held_l, s_data}); have_l = 0;
                    end else if (m_serr < CMAX) begin
                        m_serr++;
                    end
                end else begin
                    if (have_l && m_serr < CMAX) m_serr++;
                    held_l = s_data; have_l = 1;
                end
            end
            m_up = 1;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] lsamp;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        bit ok, acc;
        ok = 0;
        s_data = d; s_last = l; s_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            acc = s_ready;
            step();
            if (acc) begin
                ok = 1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ok) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL send_timeout t=%0t actual=not_accepted expected=accepted", $time);
        end
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        lsamp = l_sample;
        step();
        rd_en = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; rd_en = 1'b0;
        idle(3);
        chk("init_s_ready", 64'(s_ready), 64'd0);
        chk("init_level", 64'(level), 64'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 64'(s_ready), 64'd1);

        // Single frame round trip.
        send(24'h123456, 1'b0);
        send(24'hABCDEF, 1'b1);
        idle(4);
        pulse_rd();
        chk("t1_l_sample", 64'(lsamp), 64'h123456);
        chk("t1_rd_valid", 64'(rd_valid), 64'd1);
        chk("t1_r_sample", 64'(r_sample), 64'hABCDEF);
        idle(3);
        chk("t1_r_hold", 64'(r_sample), 64'hABCDEF);
        chk("t1_underrun", 64'(underrun_cnt), 64'd0);

        // Underruns on an empty buffer.
        for (int i = 0; i < 3; i++) begin
            pulse_rd();
            chk("t2_l_silent", 64'(lsamp), 64'd0);
            chk("t2_rd_valid", 64'(rd_valid), 64'd0);
            chk("t2_r_silent", 64'(r_sample), 64'd0);
        end
        chk("t2_underrun", 64'(underrun_cnt), 64'd3);

        // Fill to full, hold s_valid against a full FIFO, then drain in order.
        for (int i = 0; i < 17; i++) begin
            send(24'h100000 + 24'(i), 1'b0);
            send(24'h200000 + 24'(i), 1'b1);
        end
        idle(3);
        chk("t3_level_full", 64'(level), 64'd16);
        chk("t3_s_ready_low", 64'(s_ready), 64'd0);
        s_data = 24'hDEAD00; s_last = 1'b0; s_valid = 1'b1;
        idle(3);
        s_valid = 1'b0;
        chk("t3_level_blocked", 64'(level), 64'd16);
        for (int i = 0; i < 17; i++) begin
            pulse_rd();
            chk("t3_drain_l", 64'(lsamp), 64'h100000 + 64'(i));
            chk("t3_drain_r", 64'(r_sample), 64'h200000 + 64'(i));
            idle(2);
        end
        chk("t3_underrun", 64'(underrun_cnt), 64'd3);
        chk("t3_level_empty", 64'(level), 64'd0);

        // Framing errors.
        send(24'h111111, 1'b0);
        send(24'h222222, 1'b0);
        send(24'h333333, 1'b1);
        chk("t4_sync_err1", 64'(sync_err_cnt), 64'd1);
        idle(3);
        pulse_rd();
        chk("t4_l_sample", 64'(lsamp), 64'h222222);
        chk("t4_r_sample", 64'(r_sample), 64'h333333);
        send(24'h444444, 1'b1);
        chk("t4_sync_err2", 64'(sync_err_cnt), 64'd2);
        idle(2);

        // rd_en while the refill read is in flight.
        send(24'h555555, 1'b0);
        send(24'h666666, 1'b1);
        step();
        pulse_rd();
        chk("t5_inflight_l", 64'(lsamp), 64'd0);
        chk("t5_inflight_rv", 64'(rd_valid), 64'd0);
        chk("t5_underrun", 64'(underrun_cnt), 64'd4);
        pulse_rd();
        chk("t5_next_l", 64'(lsamp), 64'h555555);
        chk("t5_next_rv", 64'(rd_valid), 64'd1);
        chk("t5_next_r", 64'(r_sample), 64'h666666);
        chk("t5_underrun_kept", 64'(underrun_cnt), 64'd4);

        // Asynchronous reset with data buffered and a held L.
        for (int i = 0; i < 5; i++) begin
            send(24'h700000 + 24'(i), 1'b0);
            send(24'h800000 + 24'(i), 1'b1);
        end
        send(24'h009999, 1'b0);
        idle(4);
        chk("t6_level_pre", 64'(level), 64'd4);
        chk("t6_l_pre", 64'(l_sample), 64'h700000);
        rst = 1'b1;
        #1;
        chk("t6_async_ready", 64'(s_ready), 64'd0);
        chk("t6_async_samples", {l_sample, r_sample}, 64'd0);
        chk("t6_async_rv", 64'(rd_valid), 64'd0);
        chk("t6_async_level", 64'(level), 64'd0);
        chk("t6_async_cnts", {underrun_cnt, sync_err_cnt}, 64'd0);
        idle(2);
        rst = 1'b0;
        chk("t6_level_post", 64'(level), 64'd0);
        step();
        pulse_rd();
        chk("t6_post_rv", 64'(rd_valid), 64'd0);
        chk("t6_post_underrun", 64'(underrun_cnt), 64'd1);
        send(24'hAAAAAA, 1'b1);
        chk("t6_pairer_cleared", 64'(sync_err_cnt), 64'd1);

        // Counter saturation.
        repeat (20) pulse_rd();
        chk("t7_underrun_sat", 64'(underrun_cnt), 64'(CMAX));
        for (int i = 0; i < 20; i++) send(24'h0F0000 + 24'(i), 1'b1);
        chk("t7_sync_err_sat", 64'(sync_err_cnt), 64'(CMAX));
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
